iir_seq_ctrl: RTL and testbench

IIR_SEQ_CTRL -- requirements
Module: iir_seq_ctrl

---
 rtl/iir_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_iir_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iir_seq_ctrl
//  Description : Sequencer for a time-multiplexed, cascaded IIR filter
//                datapath. For each accepted sample it walks every active
//                section through CLEAR -> MAC (NUM_TAPS cycles) -> SHIFT and
//                then signals DONE. It drives the accumulator, the
//                coefficient/operand muxes, the history shift and the output
//                register.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_TAPS      MAC cycles per section (2..16)
//    NUM_STAGES    number of cascaded sections (1..8)
//  Ports
//    clk           system clock, rising edge
//    reset         synchronous active-high reset
//    sample_valid  new input sample available
//    stages_active sections to run for this sample (sampled at accept)
//    ovr_clr       clears the sticky overrun flag
//    sample_ready  high in IDLE only
//    busy          high in every state except IDLE
//    acc_clr       accumulator clear
//    acc_en        accumulator load enable
//    coef_sel      coefficient select = stage*NUM_TAPS + tap
//    data_sel      operand (x/y history) select = tap
//    stage_sel     index of the current section
//    hist_en       history shift enable for section stage_sel
//    out_en        output register load enable
//    result_valid  one-cycle result strobe
//    overrun       sticky flag: a sample arrived while busy
//  Configuration macro
//    IIR_OVERRUN_EN  when defined, overrun detection is built; otherwise
//                    overrun is tied to 0 and ovr_clr is ignored.
// ============================================================================
module iir_seq_ctrl #(
    parameter int NUM_TAPS   = 5,
    parameter int NUM_STAGES = 1,
    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
    localparam int SW = $clog2(NUM_STAGES + 1),
    localparam int CW = ((NUM_TAPS * NUM_STAGES) > 1) ? $clog2(NUM_TAPS * NUM_STAGES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [SW-1:0] stages_active,
    input  logic          ovr_clr,
    output logic          sample_ready,
    output logic          busy,
    output logic          acc_clr,
    output logic          acc_en,
    output logic [CW-1:0] coef_sel,
    output logic [TW-1:0] data_sel,
    output logic [SW-1:0] stage_sel,
    output logic          hist_en,
    output logic          out_en,
    output logic          result_valid,
    output logic          overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [SW-1:0] c_max_stages = SW'(NUM_STAGES);
    localparam logic [SW-1:0] c_one_stage  = SW'(1);
    localparam logic [TW-1:0] c_last_tap   = TW'(NUM_TAPS - 1);

    state_t        r_state;
    logic [TW-1:0] r_tap;
    logic [SW-1:0] r_stage;
    logic [SW-1:0] r_num_stages;
    logic [SW-1:0] w_num_clamped;
    logic [SW-1:0] w_stage_next;
    logic [CW-1:0] w_coef;

    // Section count for the sample being accepted: 0 behaves as 1 and
    // anything above the built cascade depth is limited to it.
    always_comb begin
        w_num_clamped = stages_active;
        if (stages_active == '0) begin
            w_num_clamped = c_one_stage;
        end else if (stages_active > c_max_stages) begin
            w_num_clamped = c_max_stages;
        end
    end

    // r_stage never exceeds NUM_STAGES-1, so the increment always fits SW.
    assign w_stage_next = r_stage + c_one_stage;

    // Modular CW-bit arithmetic is exact because the true product-plus-tap
    // value is always below NUM_TAPS*NUM_STAGES <= 2**CW.
    assign w_coef = (CW'(r_stage) * CW'(NUM_TAPS)) + CW'(r_tap);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tap        <= '0;
            r_stage      <= '0;
            r_num_stages <= c_one_stage;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_num_stages <= w_num_clamped;
                        r_state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_tap   <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (r_tap == c_last_tap) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_tap <= r_tap + TW'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_stage_next < r_num_stages) begin
                        r_stage <= w_stage_next;
                        r_state <= S_CLEAR;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_stage <= '0;
                    r_tap   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= '0;
                    r_tap   <= '0;
                end
            endcase
        end
    end

    // Every control output is a pure decode of the state register.
    always_comb begin
        sample_ready = 1'b0;
        busy         = 1'b1;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        coef_sel     = '0;
        data_sel     = '0;
        stage_sel    = r_stage;
        hist_en      = 1'b0;
        out_en       = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                sample_ready = 1'b1;
                busy         = 1'b0;
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
            end
            S_MAC: begin
                acc_en   = 1'b1;
                coef_sel = w_coef;
                data_sel = r_tap;
            end
            S_SHIFT: begin
                hist_en = 1'b1;
            end
            S_DONE: begin
                out_en       = 1'b1;
                result_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

`ifdef IIR_OVERRUN_EN
    logic r_overrun;

    // A new sample while busy sets the flag; set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (sample_valid && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_ovr_clr;

    assign w_unused_ovr_clr = ovr_clr;
    assign overrun          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iir_seq_ctrl
//  Description : Self-checking bench for iir_seq_ctrl (NUM_TAPS=5,
//                NUM_STAGES=2). Expected output vectors are pushed to a
//                scoreboard queue when a sample is accepted by the reference
//                model and popped one per cycle against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_seq_ctrl;

    localparam int NT = 5;
    localparam int NS = 2;
    localparam int L  = NT + 2;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int SW = $clog2(NS + 1);
    localparam int CW = ((NT * NS) > 1) ? $clog2(NT * NS) : 1;
    localparam int VW = 7 + CW + TW + SW;
    localparam logic [VW-1:0] IDLE_V = {1'b1, (VW-1)'(0)};

    logic          clk;
    logic          reset;
    logic          sample_valid;
    logic [SW-1:0] stages_active;
    logic          ovr_clr;
    logic          sample_ready;
    logic          busy;
    logic          acc_clr;
    logic          acc_en;
    logic [CW-1:0] coef_sel;
    logic [TW-1:0] data_sel;
    logic [SW-1:0] stage_sel;
    logic          hist_en;
    logic          out_en;
    logic          result_valid;
    logic          overrun;

    logic [VW-1:0] sb_q[$];
    logic [VW-1:0] cur_exp;
    logic          exp_ovr;
    int            errors;
    int            checks;

    iir_seq_ctrl #(
        .NUM_TAPS   (NT),
        .NUM_STAGES (NS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .stages_active (stages_active),
        .ovr_clr       (ovr_clr),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .acc_clr       (acc_clr),
        .acc_en        (acc_en),
        .coef_sel      (coef_sel),
        .data_sel      (data_sel),
        .stage_sel     (stage_sel),
        .hist_en       (hist_en),
        .out_en        (out_en),
        .result_valid  (result_valid),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {sample_ready, busy, acc_clr, acc_en, coef_sel, data_sel,
                stage_sel, hist_en, out_en, result_valid};
    endfunction

    // Expected outputs k cycles after the accept edge of an n-section sample.
    function automatic logic [VW-1:0] exp_vec(input int k, input int n);
        int j, s, p;
        logic rdy, bsy, clr, en, hist, oen, rv;
        logic [CW-1:0] coef;
        logic [TW-1:0] dsel;
        logic [SW-1:0] ssel;
        rdy = 1'b0; bsy = 1'b1; clr = 1'b0; en = 1'b0;
        hist = 1'b0; oen = 1'b0; rv = 1'b0;
        coef = '0; dsel = '0; ssel = '0;
        j = k - 1;
        if (j == n * L) begin
            ssel = SW'(n - 1);
            oen  = 1'b1;
            rv   = 1'b1;
        end else begin
            s = j / L;
            p = j % L;
            ssel = SW'(s);
            if (p == 0) begin
                clr = 1'b1;
            end else if (p <= NT) begin
                en   = 1'b1;
                coef = CW'(s * NT + p - 1);
                dsel = TW'(p - 1);
            end else begin
                hist = 1'b1;
            end
        end
        return {rdy, bsy, clr, en, coef, dsel, ssel, hist, oen, rv};
    endfunction

    // Drive inputs for the current cycle and advance the reference model.
    task automatic drv(input logic sv, input logic rst, input logic clr,
                       input logic [SW-1:0] sa);
        int n;
        sample_valid  = sv;
        reset         = rst;
        ovr_clr       = clr;
        stages_active = sa;
        if (rst) begin
            sb_q.delete();
            exp_ovr = 1'b0;
        end else begin
            if (sv && cur_exp[VW-1]) begin
                n = (sa == '0) ? 1 : ((int'(sa) > NS) ? NS : int'(sa));
                for (int k = 1; k <= n * L + 1; k++) sb_q.push_back(exp_vec(k, n));
            end
`ifdef IIR_OVERRUN_EN
            if (sv && !cur_exp[VW-1]) exp_ovr = 1'b1;
            else if (clr) exp_ovr = 1'b0;
`endif
        end
    endtask

    // Reset held with sample_valid and ovr_clr asserted: reset must win.
    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL reset outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL reset overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            if (c < 3) drv(1'b1, 1'b1, 1'b1, SW'(1));
            else       drv(1'b0, 1'b0, 1'b0, SW'(1));
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL single outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL single overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv(c == 0, 1'b0, 1'b0, SW'(1));
        end
    endtask

    task automatic test_two_stage();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL two_stage outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL two_stage overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv(c == 0, 1'b0, 1'b0, SW'(2));
        end
    endtask

    // stages_active=0 runs one section; stages_active=3 is limited to two.
    task automatic test_clamp();
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL clamp outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL clamp overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv((c == 0) || (c == 10), 1'b0, 1'b0, (c < 10) ? SW'(0) : SW'(3));
        end
    endtask

    task automatic test_overrun();
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL overrun outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL overrun flag c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv((c == 0) || (c == 4), 1'b0, c == 20, SW'(1));
        end
    endtask

    task automatic test_midreset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL midreset outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL midreset overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv((c == 0) || (c == 7), c == 5, 1'b0, SW'(1));
        end
    endtask

    // sample_valid held high: a sample is taken each time the FSM returns
    // to IDLE, and every busy-cycle sample is dropped as an overrun.
    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cur_exp = (sb_q.size() != 0) ? sb_q.pop_front() : IDLE_V;
            checks++;
            if (dut_vec() !== cur_exp) begin
                errors++;
                $display("FAIL back_to_back outputs c=%0d got=%h want=%h", c, dut_vec(), cur_exp);
            end
            checks++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL back_to_back overrun c=%0d got=%b want=%b", c, overrun, exp_ovr);
            end
            drv(c < 30, 1'b0, c == 38, SW'(1));
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cur_exp       = IDLE_V;
        exp_ovr       = 1'b0;
        reset         = 1'b1;
        sample_valid  = 1'b1;
        ovr_clr       = 1'b1;
        stages_active = SW'(1);

        test_reset();
        test_single();
        test_two_stage();
        test_clamp();
        test_overrun();
        test_midreset();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
